// File: rtl/fir_stream.sv
// fir_stream -- streaming, programmable-coefficient FIR filter.
//
// Each accepted sample (i_valid=1) is shifted into a delay line. On the next
// edge every tap product is registered, and on the edge after that the
// products are summed, arithmetically shifted right by SHIFT and narrowed to
// NB_OUT bits. Overflow either saturates or wraps, depending on i_sat, and is
// flagged on o_ovf. Coefficients can be rewritten at run time through a simple
// write strobe and reset to the identity filter (c[0]=1, all others 0).
//
// Ports
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_valid      i_data carries a sample this cycle
//   i_data       input sample, signed, NB_DATA bits
//   i_clear      synchronous flush of the delay line and pipeline (coefs kept)
//   i_sat        1 = saturate on overflow, 0 = keep the low NB_OUT bits
//   i_coef_we    coefficient write strobe
//   i_coef_addr  tap index to write; indices >= N_TAPS are ignored
//   i_coef_data  coefficient value, signed, NB_COEF bits
//   o_valid      o_data/o_ovf carry a new result
//   o_data       filtered result, signed, NB_OUT bits
//   o_ovf        the narrowing of this result overflowed
//
// Timing: a sample taken on edge E0 has its result on o_data, with o_valid
// high, right after edge E0+2. Three valid flags follow the data through the
// pipe (delay line, product stage, output stage).

module fir_stream #(
  parameter int NB_DATA = 8,
  parameter int NB_COEF = 8,
  parameter int N_TAPS  = 8,
  parameter int NB_OUT  = 8,
  parameter int SHIFT   = 0
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  input  logic [NB_DATA-1:0]        i_data,
  input  logic                      i_clear,
  input  logic                      i_sat,
  input  logic                      i_coef_we,
  input  logic [$clog2(N_TAPS)-1:0] i_coef_addr,
  input  logic [NB_COEF-1:0]        i_coef_data,
  output logic                      o_valid,
  output logic [NB_OUT-1:0]         o_data,
  output logic                      o_ovf
);

  localparam int NB_ADDR = $clog2(N_TAPS);
  localparam int NB_PROD = NB_DATA + NB_COEF;
  // Guard bits make the tap sum exact for any coefficient/data values.
  localparam int NB_ACC  = NB_PROD + $clog2(N_TAPS);
  // Working width for the range check: wide enough for both the sum and the
  // output limits, plus one bit so the limits never alias the sign.
  localparam int NB_W    = ((NB_ACC > NB_OUT) ? NB_ACC : NB_OUT) + 1;

  localparam logic [NB_COEF-1:0] C_ONE  = {{(NB_COEF-1){1'b0}}, 1'b1};
  localparam logic [NB_COEF-1:0] C_ZERO = {NB_COEF{1'b0}};

  // Full-precision signed product; operands are sign-extended first so the
  // multiply is evaluated at the product width.
  function automatic logic signed [NB_PROD-1:0] mul_s(
    input logic signed [NB_DATA-1:0] a,
    input logic signed [NB_COEF-1:0] b
  );
    logic signed [NB_PROD-1:0] a_e;
    logic signed [NB_PROD-1:0] b_e;
    a_e = {{NB_COEF{a[NB_DATA-1]}}, a};
    b_e = {{NB_DATA{b[NB_COEF-1]}}, b};
    return a_e * b_e;
  endfunction

  // Sign-extend one product to accumulator width.
  function automatic logic signed [NB_ACC-1:0] sext_p(
    input logic signed [NB_PROD-1:0] p
  );
    return {{(NB_ACC-NB_PROD){p[NB_PROD-1]}}, p};
  endfunction

  // Narrow the shifted sum to NB_OUT bits. Returns {ovf, data}.
  function automatic logic [NB_OUT:0] narrow(
    input logic signed [NB_ACC-1:0] s,
    input logic                     sat
  );
    logic signed [NB_W-1:0] s_w;
    logic signed [NB_W-1:0] max_w;
    logic signed [NB_W-1:0] min_w;
    logic        [NB_OUT:0] r;
    s_w   = {{(NB_W-NB_ACC){s[NB_ACC-1]}}, s};
    max_w = {{(NB_W-NB_OUT+1){1'b0}}, {(NB_OUT-1){1'b1}}};
    min_w = {{(NB_W-NB_OUT+1){1'b1}}, {(NB_OUT-1){1'b0}}};
    if (s_w > max_w) begin
      if (sat) begin
        r = {1'b1, 1'b0, {(NB_OUT-1){1'b1}}};
      end else begin
        r = {1'b1, s_w[NB_OUT-1:0]};
      end
    end else if (s_w < min_w) begin
      if (sat) begin
        r = {1'b1, 1'b1, {(NB_OUT-1){1'b0}}};
      end else begin
        r = {1'b1, s_w[NB_OUT-1:0]};
      end
    end else begin
      r = {1'b0, s_w[NB_OUT-1:0]};
    end
    return r;
  endfunction

  // State
  logic signed [NB_DATA-1:0] x_q [N_TAPS];
  logic signed [NB_DATA-1:0] x_d [N_TAPS];
  logic signed [NB_PROD-1:0] p_q [N_TAPS];
  logic signed [NB_PROD-1:0] p_d [N_TAPS];
  logic signed [NB_COEF-1:0] c_q [N_TAPS];
  logic signed [NB_COEF-1:0] c_d [N_TAPS];
  logic                      x_vld_q;
  logic                      x_vld_d;
  logic                      v1_q;
  logic                      v1_d;
  logic                      o_valid_q;
  logic                      o_valid_d;
  logic [NB_OUT-1:0]         o_data_q;
  logic [NB_OUT-1:0]         o_data_d;
  logic                      o_ovf_q;
  logic                      o_ovf_d;

  // Combinational datapath
  logic signed [NB_ACC-1:0]  acc_s;
  logic signed [NB_ACC-1:0]  sh_s;
  logic [NB_OUT:0]           nar_s;

  // Delay line: shift on an accepted sample, hold when idle, flush on clear.
  always_comb begin
    x_d     = x_q;
    x_vld_d = 1'b0;
    if (i_clear) begin
      for (int k = 0; k < N_TAPS; k++) begin
        x_d[k] = '0;
      end
      x_vld_d = 1'b0;
    end else if (i_valid) begin
      x_d[0] = i_data;
      for (int k = 1; k < N_TAPS; k++) begin
        x_d[k] = x_q[k-1];
      end
      x_vld_d = 1'b1;
    end else begin
      x_vld_d = 1'b0;
    end
  end

  // Product stage: registered x[k]*c[k]; uses the coefficients held before
  // this edge, so a write on the same edge only affects later products.
  always_comb begin
    for (int k = 0; k < N_TAPS; k++) begin
      p_d[k] = '0;
    end
    v1_d = 1'b0;
    if (i_clear) begin
      v1_d = 1'b0;
    end else begin
      for (int k = 0; k < N_TAPS; k++) begin
        p_d[k] = mul_s(x_q[k], c_q[k]);
      end
      v1_d = x_vld_q;
    end
  end

  // Tap sum, arithmetic scaling and narrowing of the registered products.
  always_comb begin
    acc_s = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      acc_s = acc_s + sext_p(p_q[k]);
    end
    sh_s  = acc_s >>> SHIFT;
    nar_s = narrow(sh_s, i_sat);
  end

  // Output stage: data and overflow only move with a valid product set.
  always_comb begin
    o_valid_d = 1'b0;
    o_data_d  = o_data_q;
    o_ovf_d   = o_ovf_q;
    if (i_clear) begin
      o_valid_d = 1'b0;
    end else if (v1_q) begin
      o_valid_d = 1'b1;
      o_ovf_d   = nar_s[NB_OUT];
      o_data_d  = nar_s[NB_OUT-1:0];
    end else begin
      o_valid_d = 1'b0;
    end
  end

  // Coefficient writes; an address past the last tap matches no entry.
  always_comb begin
    c_d = c_q;
    for (int k = 0; k < N_TAPS; k++) begin
      if (i_coef_we && (i_coef_addr == NB_ADDR'(k))) begin
        c_d[k] = i_coef_data;
      end else begin
        c_d[k] = c_q[k];
      end
    end
  end

  // State registers; reset empties the pipe and restores identity coefficients.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < N_TAPS; k++) begin
        x_q[k] <= '0;
        p_q[k] <= '0;
        c_q[k] <= (k == 0) ? C_ONE : C_ZERO;
      end
      x_vld_q   <= 1'b0;
      v1_q      <= 1'b0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_ovf_q   <= 1'b0;
    end else begin
      x_q       <= x_d;
      p_q       <= p_d;
      c_q       <= c_d;
      x_vld_q   <= x_vld_d;
      v1_q      <= v1_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_ovf_q   <= o_ovf_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_ovf   = o_ovf_q;

endmodule

// File: tb/tb_fir_stream.sv
// tb_fir_stream -- directed bench for fir_stream.
// Main instance: 8 taps, 8-bit data/coef/out, SHIFT=0. A second 6-tap
// instance shares every input so that out-of-range coefficient addresses
// (6 and 7) can be driven through the 3-bit address port.
// Inputs change #1 after a rising edge; outputs are read at that same point.

module tb_fir_stream;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_valid;
  logic [7:0] i_data;
  logic       i_clear;
  logic       i_sat;
  logic       i_coef_we;
  logic [2:0] i_coef_addr;
  logic [7:0] i_coef_data;
  logic       o_valid;
  logic [7:0] o_data;
  logic       o_ovf;
  logic       o_valid6;
  logic [7:0] o_data6;
  logic       o_ovf6;

  int tests_run;
  int tests_failed;

  logic       vpat[$];
  logic [7:0] got_d[$];
  logic       got_ovf[$];
  logic [7:0] got6[$];
  logic       got6_ovf[$];

  fir_stream #(.NB_DATA(8), .NB_COEF(8), .N_TAPS(8), .NB_OUT(8), .SHIFT(0)) u_dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_data(i_data),
    .i_clear(i_clear), .i_sat(i_sat), .i_coef_we(i_coef_we),
    .i_coef_addr(i_coef_addr), .i_coef_data(i_coef_data),
    .o_valid(o_valid), .o_data(o_data), .o_ovf(o_ovf)
  );

  fir_stream #(.NB_DATA(8), .NB_COEF(8), .N_TAPS(6), .NB_OUT(8), .SHIFT(0)) u_dut6 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_data(i_data),
    .i_clear(i_clear), .i_sat(i_sat), .i_coef_we(i_coef_we),
    .i_coef_addr(i_coef_addr), .i_coef_data(i_coef_data),
    .o_valid(o_valid6), .o_data(o_data6), .o_ovf(o_ovf6)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end, want summary before 200000");
    $fatal(1);
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
    vpat.push_back(o_valid);
    if (o_valid) begin
      got_d.push_back(o_data);
      got_ovf.push_back(o_ovf);
    end
    if (o_valid6) begin
      got6.push_back(o_data6);
      got6_ovf.push_back(o_ovf6);
    end
  endtask

  task automatic clear_obs();
    vpat.delete();
    got_d.delete();
    got_ovf.delete();
    got6.delete();
    got6_ovf.delete();
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    i_valid = v;
    i_data  = d;
    tick();
    i_valid = 1'b0;
    i_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00);
  endtask

  task automatic pulse_clear();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
  endtask

  task automatic write_coef(input logic [2:0] a, input logic [7:0] d);
    i_coef_we   = 1'b1;
    i_coef_addr = a;
    i_coef_data = d;
    tick();
    i_coef_we   = 1'b0;
  endtask

  task automatic load_coefs(input logic [7:0] c [8]);
    for (int k = 0; k < 8; k++) write_coef(3'(k), c[k]);
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_valid = 1'b1;
    i_data  = 8'h05;
    repeat (2) @(posedge i_clk);
    #1;
    tests_run++;
    if (o_valid !== 1'b0 || o_data !== 8'h00 || o_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got valid=%b data=%h ovf=%b, want 0 00 0", o_valid, o_data, o_ovf);
    end
    i_valid = 1'b0;
    i_data  = 8'h00;
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic test_identity(input string tag);
    logic [4:0] pat;
    clear_obs();
    drive(1'b1, 8'h05);
    drive(1'b1, 8'hFD);
    idle(3);
    pat = 5'b0;
    for (int i = 0; i < 5 && i < vpat.size(); i++) pat[4-i] = vpat[i];
    tests_run++;
    if (vpat.size() != 5 || pat !== 5'b00110) begin
      tests_failed++;
      $display("FAIL %s_valid_pattern: got %b, want 00110", tag, pat);
    end
    tests_run++;
    if (got_d.size() != 2) begin
      tests_failed++;
      $display("FAIL %s_count: got %0d results, want 2", tag, got_d.size());
    end else if (got_d[0] !== 8'h05 || got_d[1] !== 8'hFD) begin
      tests_failed++;
      $display("FAIL %s_data: got %h %h, want 05 fd", tag, got_d[0], got_d[1]);
    end
  endtask

  task automatic test_impulse();
    logic [7:0] c   [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
    logic [7:0] exp [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
    load_coefs(c);
    pulse_clear();
    clear_obs();
    drive(1'b1, 8'h01);
    repeat (7) drive(1'b1, 8'h00);
    idle(2);
    tests_run++;
    if (vpat.size() != 10 || vpat[0] !== 1'b0 || vpat[1] !== 1'b0 || vpat[2] !== 1'b1) begin
      tests_failed++;
      $display("FAIL impulse_latency: got first valids %b%b%b, want 001", vpat[0], vpat[1], vpat[2]);
    end
    tests_run++;
    if (got_d.size() != 8) begin
      tests_failed++;
      $display("FAIL impulse_count: got %0d results, want 8", got_d.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests_run++;
        if (got_d[i] !== exp[i] || got_ovf[i] !== 1'b0) begin
          tests_failed++;
          $display("FAIL impulse_data[%0d]: got %h ovf=%b, want %h ovf=0", i, got_d[i], got_ovf[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic [7:0] c [8] = '{default: 8'h7F};
    load_coefs(c);
    // 127*127 per tap: every partial window overflows; 8 taps give 129032.
    i_sat = 1'b1;
    pulse_clear();
    clear_obs();
    repeat (8) drive(1'b1, 8'h7F);
    idle(2);
    tests_run++;
    if (got_d.size() != 8) begin
      tests_failed++;
      $display("FAIL sat_pos_count: got %0d results, want 8", got_d.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests_run++;
        if (got_d[i] !== 8'h7F || got_ovf[i] !== 1'b1) begin
          tests_failed++;
          $display("FAIL sat_pos[%0d]: got %h ovf=%b, want 7f ovf=1", i, got_d[i], got_ovf[i]);
        end
      end
    end
    // Wrap: k*16129 mod 256 = k.
    i_sat = 1'b0;
    pulse_clear();
    clear_obs();
    repeat (8) drive(1'b1, 8'h7F);
    idle(2);
    tests_run++;
    if (got_d.size() != 8) begin
      tests_failed++;
      $display("FAIL wrap_count: got %0d results, want 8", got_d.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests_run++;
        if (got_d[i] !== 8'(i + 1) || got_ovf[i] !== 1'b1) begin
          tests_failed++;
          $display("FAIL wrap[%0d]: got %h ovf=%b, want %h ovf=1", i, got_d[i], got_ovf[i], 8'(i + 1));
        end
      end
    end
    i_sat = 1'b1;
    pulse_clear();
    clear_obs();
    repeat (8) drive(1'b1, 8'h80);
    idle(2);
    tests_run++;
    if (got_d.size() != 8 || got_d[7] !== 8'h80 || got_ovf[7] !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_neg: got %0d results last=%h ovf=%b, want 8 results last=80 ovf=1",
               got_d.size(), (got_d.size() > 7) ? got_d[7] : 8'hxx, (got_ovf.size() > 7) ? got_ovf[7] : 1'bx);
    end
  endtask

  task automatic test_boundary();
    logic [7:0] c      [8] = '{8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    logic [7:0] in_v   [4] = '{8'h7F, 8'h01, 8'h80, 8'hFF};
    // sums: 127, 128, -127, -129
    logic [7:0] exp_s  [4] = '{8'h7F, 8'h7F, 8'h81, 8'h80};
    logic [7:0] exp_w  [4] = '{8'h7F, 8'h80, 8'h81, 8'h7F};
    logic       exp_o  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    load_coefs(c);
    for (int m = 0; m < 2; m++) begin
      i_sat = (m == 0);
      pulse_clear();
      clear_obs();
      for (int i = 0; i < 4; i++) drive(1'b1, in_v[i]);
      idle(2);
      tests_run++;
      if (got_d.size() != 4) begin
        tests_failed++;
        $display("FAIL boundary_count sat=%b: got %0d results, want 4", i_sat, got_d.size());
      end else begin
        for (int i = 0; i < 4; i++) begin
          tests_run++;
          if (got_d[i] !== ((m == 0) ? exp_s[i] : exp_w[i]) || got_ovf[i] !== exp_o[i]) begin
            tests_failed++;
            $display("FAIL boundary[%0d] sat=%b: got %h ovf=%b, want %h ovf=%b", i, i_sat,
                     got_d[i], got_ovf[i], (m == 0) ? exp_s[i] : exp_w[i], exp_o[i]);
          end
        end
      end
    end
    i_sat = 1'b1;
  endtask

  task automatic test_gapped();
    logic [7:0] c   [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
    logic [7:0] exp [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
    logic       e;
    load_coefs(c);
    pulse_clear();
    clear_obs();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, (i == 0) ? 8'h01 : 8'h00);
      drive(1'b0, 8'h37);
      drive(1'b0, 8'h37);
    end
    idle(2);
    tests_run++;
    if (vpat.size() != 26) begin
      tests_failed++;
      $display("FAIL gapped_cycles: got %0d, want 26", vpat.size());
    end else begin
      for (int t = 0; t < 26; t++) begin
        e = (t >= 2) && (((t - 2) % 3) == 0) && (((t - 2) / 3) < 8);
        tests_run++;
        if (vpat[t] !== e) begin
          tests_failed++;
          $display("FAIL gapped_valid[%0d]: got %b, want %b", t, vpat[t], e);
        end
      end
    end
    tests_run++;
    if (got_d.size() != 8) begin
      tests_failed++;
      $display("FAIL gapped_count: got %0d results, want 8", got_d.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests_run++;
        if (got_d[i] !== exp[i]) begin
          tests_failed++;
          $display("FAIL gapped_data[%0d]: got %h, want %h", i, got_d[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_clear_mid();
    logic [7:0] exp [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
    logic       e;
    pulse_clear();
    clear_obs();
    drive(1'b1, 8'h01);
    drive(1'b1, 8'h05);
    i_clear = 1'b1;
    drive(1'b1, 8'h07);
    i_clear = 1'b0;
    drive(1'b1, 8'h01);
    repeat (7) drive(1'b1, 8'h00);
    idle(2);
    tests_run++;
    if (vpat.size() != 13) begin
      tests_failed++;
      $display("FAIL clear_cycles: got %0d, want 13", vpat.size());
    end else begin
      for (int t = 0; t < 13; t++) begin
        e = (t >= 5);
        tests_run++;
        if (vpat[t] !== e) begin
          tests_failed++;
          $display("FAIL clear_valid[%0d]: got %b, want %b", t, vpat[t], e);
        end
      end
    end
    tests_run++;
    if (got_d.size() != 8) begin
      tests_failed++;
      $display("FAIL clear_count: got %0d results, want 8", got_d.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests_run++;
        if (got_d[i] !== exp[i]) begin
          tests_failed++;
          $display("FAIL clear_data[%0d]: got %h, want %h", i, got_d[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    pulse_clear();
    drive(1'b1, 8'h01);
    drive(1'b1, 8'h00);
    drive(1'b1, 8'h00);
    tests_run++;
    if (o_valid !== 1'b1 || o_data !== 8'h01) begin
      tests_failed++;
      $display("FAIL pre_reset_stream: got valid=%b data=%h, want 1 01", o_valid, o_data);
    end
    i_valid = 1'b1;
    i_data  = 8'h00;
    #2;
    i_rst_n = 1'b0;
    #1;
    tests_run++;
    if (o_valid !== 1'b0 || o_data !== 8'h00 || o_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got valid=%b data=%h ovf=%b, want 0 00 0", o_valid, o_data, o_ovf);
    end
    i_valid = 1'b0;
    i_rst_n = 1'b1;
    // Identity coefficients again: -3 after 5 must give -3, not 7.
    test_identity("after_reset");
  endtask

  task automatic test_live_coef();
    logic [7:0] exp [8] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h0B, 8'h0B, 8'h0B, 8'h0B};
    pulse_clear();
    clear_obs();
    repeat (4) drive(1'b1, 8'h01);
    i_coef_we   = 1'b1;
    i_coef_addr = 3'd1;
    i_coef_data = 8'h0A;
    drive(1'b1, 8'h01);
    i_coef_we   = 1'b0;
    repeat (3) drive(1'b1, 8'h01);
    idle(2);
    tests_run++;
    if (got_d.size() != 8) begin
      tests_failed++;
      $display("FAIL live_count: got %0d results, want 8", got_d.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests_run++;
        if (got_d[i] !== exp[i]) begin
          tests_failed++;
          $display("FAIL live_data[%0d]: got %h, want %h", i, got_d[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_bad_addr();
    // 6-tap instance holds c = 1,10,0,0,0,0; addresses 6 and 7 do not exist.
    write_coef(3'd6, 8'h32);
    write_coef(3'd7, 8'h32);
    pulse_clear();
    clear_obs();
    repeat (8) drive(1'b1, 8'h01);
    idle(2);
    tests_run++;
    if (got6.size() != 8) begin
      tests_failed++;
      $display("FAIL bad_addr_count: got %0d results, want 8", got6.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests_run++;
        if (got6[i] !== ((i == 0) ? 8'h01 : 8'h0B) || got6_ovf[i] !== 1'b0) begin
          tests_failed++;
          $display("FAIL bad_addr_data[%0d]: got %h ovf=%b, want %h ovf=0", i, got6[i], got6_ovf[i],
                   (i == 0) ? 8'h01 : 8'h0B);
        end
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    i_rst_n      = 1'b0;
    i_valid      = 1'b0;
    i_data       = 8'h00;
    i_clear      = 1'b0;
    i_sat        = 1'b1;
    i_coef_we    = 1'b0;
    i_coef_addr  = 3'd0;
    i_coef_data  = 8'h00;

    test_reset();
    test_identity("identity");
    test_impulse();
    test_saturation();
    test_boundary();
    test_gapped();
    test_clear_mid();
    test_async_reset();
    test_live_coef();
    test_bad_addr();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
